serial_frame_deserializer: RTL

- Downstream consumer of the SISO shift-register stage: takes its serial output bit stream, one bit per clock.
- Detects framed words, reassembles them MSB-first into parallel data, and presents them on a valid/ready output with a one-entry holding register.
- Flags malformed frames and overruns.

---
 rtl/serial_frame_pkg.sv | 16 +
 rtl/serial_out_holding_reg.sv | 39 +++
 rtl/serial_frame_deserializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame deserializer: FSM state encoding and
// the line levels that delimit a frame.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_out_holding_reg.sv
// One-entry valid/ready output buffer. A word offered while the entry is full
// and not draining is dropped and reported with a one-cycle overrun pulse.
module serial_out_holding_reg
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              overrun
);

  logic accept;

  // A full entry may still take the new word when it transfers on the same edge.
  assign accept = load && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= load && out_valid && !out_ready;
      if (accept) begin
        out_data  <= load_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Reassembles start/payload/stop framed serial words MSB-first into parallel data.
// Optional even-parity bit and parity_err output when SERIAL_FRAME_PARITY_EN is defined.
module serial_frame_deserializer
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun
`ifdef SERIAL_FRAME_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state;
  state_t            nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              shift_en;
  logic              load;
  logic              ferr_nxt;
`ifdef SERIAL_FRAME_PARITY_EN
  logic              par_bad;
  logic              perr_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (si == START_BIT) nxt = DATA;
      DATA: begin
        if (cnt == LAST_CNT) begin
`ifdef SERIAL_FRAME_PARITY_EN
          nxt = PARITY;
`else
          nxt = STOP;
`endif
        end
      end
      PARITY: nxt = STOP;
      STOP:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // A wrong stop bit outranks a parity mismatch; only clean frames reach the buffer.
  always_comb begin
    shift_en = 1'b0;
    load     = 1'b0;
    ferr_nxt = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
    perr_nxt = 1'b0;
`endif
    case (state)
      DATA: shift_en = 1'b1;
      STOP: begin
        if (si != STOP_BIT) ferr_nxt = 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
        else if (par_bad) perr_nxt = 1'b1;
`endif
        else load = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      shreg     <= {DATA_W{IDLE_LEVEL}};
      frame_err <= 1'b0;
    end else begin
      frame_err <= ferr_nxt;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt   <= cnt + CNT_W'(1);
        shreg <= {shreg[DATA_W-2:0], si};
      end
    end
  end

`ifdef SERIAL_FRAME_PARITY_EN
  // Payload plus parity must carry an even number of ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_nxt;
      if (state == PARITY) par_bad <= ^{shreg, si};
    end
  end
`endif

  serial_out_holding_reg #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (shreg),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule
